t3d_poll_sched: RTL and testbench

//  Schedules and arbitrates the single half-duplex RS485 link to a T3D absolute encoder among NREQ requesters
//  (periodic position poll, alarm clear, EEPROM/ID reads). Grants one requester at a time (round-robin) and

---
 rtl/t3d_poll_sched_if.sv | 29 ++
 rtl/t3d_poll_sched.sv | 187 ++++++++++++++++++
 tb/tb_t3d_poll_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t3d_poll_sched_if.sv
// Requester and RS485 datapath signals of the T3D poll scheduler.
// The slave modport is the scheduler; the master modport is the surrounding system.
interface t3d_poll_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] cmd;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              resp_ok;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_enable;
  logic              rx_endofpacket;
  logic              rx_frame_ok;
  logic              busy;
  logic [15:0]       err_count;

  modport master (
    output req, cmd, tx_busy, rx_endofpacket, rx_frame_ok,
    input  grant, done, resp_ok, tx_start, tx_data, tx_enable, busy, err_count
  );

  modport slave (
    input  req, cmd, tx_busy, rx_endofpacket, rx_frame_ok,
    output grant, done, resp_ok, tx_start, tx_data, tx_enable, busy, err_count
  );
endinterface

// File: rtl/t3d_poll_sched.sv
// Round-robin scheduler for the half-duplex RS485 link to a T3D encoder: sends one
// command byte per grant, waits for the reply or a timeout, then holds a turnaround gap.
module t3d_poll_sched #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 32400,
  parameter int GAP_CYC     = 324
) (
  input  logic            clk,
  input  logic            rst_n,
  t3d_poll_sched_if.slave bus
);
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYC - 1);
  localparam logic [PW-1:0] LAST_IDX     = PW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_TXWAIT,
    S_RXWAIT,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     winner_q, winner_d;
  logic [CW-1:0]     counter_q, counter_d;
  logic              txw_first_q, txw_first_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              resp_ok_q, resp_ok_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_enable_q, tx_enable_d;
  logic              busy_q, busy_d;
  logic [15:0]       err_count_q, err_count_d;

  logic [PW-1:0]     pick;
  logic [8*NREQ-1:0] cmd_shift;
  logic [15:0]       err_count_inc;

  // First requesting index at or after ptr, wrapping at NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] ptr);
    logic [PW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!found && (((r >> idx) & NREQ'(1)) != '0)) begin
        sel   = PW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick          = rr_pick(bus.req, rr_ptr_q);
  assign cmd_shift     = bus.cmd >> {winner_q, 3'b000};
  assign err_count_inc = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  // NOTE: every variable gets its hold/default value first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    counter_d   = counter_q;
    txw_first_d = txw_first_q;
    grant_d     = grant_q;
    done_d      = '0;
    resp_ok_d   = resp_ok_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_enable_d = tx_enable_q;
    err_count_d = err_count_q;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (bus.req != '0) begin
          winner_d = pick;
          grant_d  = NREQ'(1) << pick;
          rr_ptr_d = (pick == LAST_IDX) ? '0 : pick + PW'(1);
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d   = cmd_shift[7:0];
          tx_start_d  = 1'b1;
          tx_enable_d = 1'b1;
          txw_first_d = 1'b1;
          state_d     = S_TXWAIT;
        end
      end
      S_TXWAIT: begin
        // uart_tx raises busy one cycle after the strobe, so the first cycle is blind.
        if (txw_first_q) begin
          txw_first_d = 1'b0;
        end else if (!bus.tx_busy) begin
          tx_enable_d = 1'b0;
          counter_d   = TIMEOUT_LOAD;
          state_d     = S_RXWAIT;
        end
      end
      S_RXWAIT: begin
        if (bus.rx_endofpacket) begin
          done_d    = grant_q;
          resp_ok_d = bus.rx_frame_ok;
          if (!bus.rx_frame_ok) err_count_d = err_count_inc;
          counter_d = GAP_LOAD;
          state_d   = S_GAP;
        end else if (counter_q == '0) begin
          done_d      = grant_q;
          resp_ok_d   = 1'b0;
          err_count_d = err_count_inc;
          counter_d   = GAP_LOAD;
          state_d     = S_GAP;
        end else begin
          counter_d = counter_q - CW'(1);
        end
      end
      S_GAP: begin
        if (counter_q == '0) begin
          tx_enable_d = 1'b1;
          grant_d     = '0;
          state_d     = S_IDLE;
        end else begin
          counter_d = counter_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      counter_q   <= '0;
      txw_first_q <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      resp_ok_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_enable_q <= 1'b1;
      busy_q      <= 1'b0;
      err_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      counter_q   <= counter_d;
      txw_first_q <= txw_first_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      resp_ok_q   <= resp_ok_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      tx_enable_q <= tx_enable_d;
      busy_q      <= busy_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.resp_ok   = resp_ok_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_enable = tx_enable_q;
  assign bus.busy      = busy_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_t3d_poll_sched.sv
// Directed bench for t3d_poll_sched with a uart_tx busy model; expected values are hand-derived.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_t3d_poll_sched;
  localparam int NREQ        = 4;
  localparam int TIMEOUT_CYC = 40;
  localparam int GAP_CYC     = 6;
  localparam int TX_CYC      = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  t3d_poll_sched_if #(.NREQ(NREQ)) bus ();

  t3d_poll_sched #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GAP_CYC     (GAP_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy for TX_CYC sampled edges after each start strobe.
  int         busy_left     = 0;
  int         busy_fall_cyc = 0;
  int         tx_starts     = 0;
  int         done_pulses   = 0;
  logic [7:0] last_tx       = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_busy = 1'b0;
      busy_left   = 0;
    end else if (bus.tx_start) begin
      last_tx     = bus.tx_data;
      tx_starts++;
      bus.tx_busy = 1'b1;
      busy_left   = TX_CYC - 1;
    end else if (bus.tx_busy) begin
      if (busy_left > 0) busy_left--;
      else begin
        bus.tx_busy   = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
    if (bus.done != '0) done_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- bounded wait helpers ----------------
  task automatic wait_grant(input string name, output logic [NREQ-1:0] g);
    int n;
    n = 0;
    while (bus.grant == '0 && n < 100) begin @(negedge clk); n++; end
    g = bus.grant;
    if (g == '0) begin
      checks++; fails++;
      $display("FAIL %s_grant_wait: no grant after %0d cycles", name, n);
    end
  endtask

  task automatic wait_rxwait(input string name);
    int n;
    n = 0;
    while (!(bus.busy && !bus.tx_enable) && n < 100) begin @(negedge clk); n++; end
    if (bus.tx_enable) begin
      checks++; fails++;
      $display("FAIL %s_rx_wait: tx_enable still %b after %0d cycles", name, bus.tx_enable, n);
    end
  endtask

  task automatic wait_done(input string name, output logic [NREQ-1:0] d, output logic ok, output int at);
    int n;
    n = 0;
    while (bus.done == '0 && n < TIMEOUT_CYC + 50) begin @(negedge clk); n++; end
    d  = bus.done;
    ok = bus.resp_ok;
    at = cyc;
    if (d == '0) begin
      checks++; fails++;
      $display("FAIL %s_done_wait: no done after %0d cycles", name, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < TIMEOUT_CYC + 50) begin @(negedge clk); n++; end
    if (bus.busy) begin
      checks++; fails++;
      $display("FAIL %s_idle_wait: still busy after %0d cycles", name, n);
    end
  endtask

  task automatic pulse_eop(input logic ok);
    bus.rx_frame_ok    = ok;
    bus.rx_endofpacket = 1'b1;
    @(negedge clk);
    bus.rx_endofpacket = 1'b0;
    bus.rx_frame_ok    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    checks++; if (bus.done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b want 0000", bus.done); end
    checks++; if (bus.resp_ok !== 1'b0) begin fails++; $display("FAIL reset_resp_ok: got %b want 0", bus.resp_ok); end
    checks++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    checks++; if (bus.tx_enable !== 1'b1) begin fails++; $display("FAIL reset_tx_enable: got %b want 1", bus.tx_enable); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.err_count !== 16'h0000) begin fails++; $display("FAIL reset_err_count: got %h want 0000", bus.err_count); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
      fails++; $display("FAIL reset_idle_no_req: busy=%b grant=%b want 0/0000", bus.busy, bus.grant);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g, d;
    logic            ok;
    int              at, starts0;
    starts0       = tx_starts;
    bus.cmd[7:0]  = 8'h02;
    bus.req       = 4'b0001;
    wait_grant("single", g);
    bus.req = 4'b0000;
    checks++; if (g !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", g); end
    checks++; if (bus.busy !== 1'b1 || bus.tx_enable !== 1'b1) begin
      fails++; $display("FAIL single_send_state: busy=%b tx_enable=%b want 1/1", bus.busy, bus.tx_enable);
    end
    wait_rxwait("single");
    bus.cmd[7:0] = 8'hFF;
    checks++; if (last_tx !== 8'h02) begin fails++; $display("FAIL single_tx_data: got %h want 02", last_tx); end
    checks++; if (tx_starts - starts0 !== 1) begin fails++; $display("FAIL single_tx_start_width: got %0d want 1", tx_starts - starts0); end
    checks++; if (bus.tx_busy !== 1'b0 || bus.tx_enable !== 1'b0) begin
      fails++; $display("FAIL single_enable_after_busy: tx_busy=%b tx_enable=%b want 0/0", bus.tx_busy, bus.tx_enable);
    end
    repeat (3) @(negedge clk);
    pulse_eop(1'b1);
    wait_done("single", d, ok, at);
    checks++; if (d !== 4'b0001) begin fails++; $display("FAIL single_done: got %b want 0001", d); end
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL single_resp_ok: got %b want 1", ok); end
    checks++; if (bus.err_count !== 16'h0000) begin fails++; $display("FAIL single_err_count: got %h want 0000", bus.err_count); end
    @(negedge clk);
    checks++; if (bus.done !== 4'b0000) begin fails++; $display("FAIL single_done_width: got %b want 0000", bus.done); end
    checks++; if (bus.tx_data !== 8'h02) begin fails++; $display("FAIL single_cmd_capture: got %h want 02", bus.tx_data); end
    wait_idle("single");
    checks++; if (bus.tx_enable !== 1'b1 || bus.grant !== 4'b0000) begin
      fails++; $display("FAIL single_back_idle: tx_enable=%b grant=%b want 1/0000", bus.tx_enable, bus.grant);
    end
  endtask

  task automatic run_rr(input string name, input logic [NREQ-1:0] r, input int n, input int first_k);
    logic [NREQ-1:0] g, d, exp_g;
    logic            ok;
    logic [7:0]      exp_b;
    int              at, idx;
    int              order_rr[$];
    int              order_pair[$];
    order_rr   = '{0, 1, 2, 3, 0, 1, 2, 3};
    order_pair = '{0, 3, 0};
    bus.req = r;
    for (int k = 0; k < n; k++) begin
      idx   = (first_k == 0) ? order_rr[k] : order_pair[k];
      exp_g = 4'(4'b0001 << idx);
      exp_b = 8'h10 + 8'(idx);
      wait_grant(name, g);
      if (k == n - 1) bus.req = 4'b0000;
      checks++; if (g !== exp_g) begin fails++; $display("FAIL %s_grant_%0d: got %b want %b", name, k, g, exp_g); end
      wait_rxwait(name);
      checks++; if (last_tx !== exp_b) begin fails++; $display("FAIL %s_tx_data_%0d: got %h want %h", name, k, last_tx, exp_b); end
      pulse_eop(1'b1);
      wait_done(name, d, ok, at);
      wait_idle(name);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.cmd = {8'h13, 8'h12, 8'h11, 8'h10};
    run_rr("rr_all", 4'b1111, 8, 0);
    run_rr("rr_wrap", 4'b1001, 3, 1);
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] g, d;
    logic            ok;
    int              at, fall, n;
    bus.req = 4'b0010;
    wait_grant("timeout", g);
    bus.req = 4'b0000;
    checks++; if (g !== 4'b0010) begin fails++; $display("FAIL timeout_grant: got %b want 0010", g); end
    wait_rxwait("timeout");
    fall = busy_fall_cyc;
    wait_done("timeout", d, ok, at);
    // busy falls at negedge 'fall'; the DUT samples it at the next edge and times out TIMEOUT_CYC edges later.
    checks++; if (at !== fall + 1 + TIMEOUT_CYC) begin fails++; $display("FAIL timeout_latency: got %0d want %0d", at - fall - 1, TIMEOUT_CYC); end
    checks++; if (d !== 4'b0010) begin fails++; $display("FAIL timeout_done: got %b want 0010", d); end
    checks++; if (ok !== 1'b0) begin fails++; $display("FAIL timeout_resp_ok: got %b want 0", ok); end
    checks++; if (bus.err_count !== 16'd1) begin fails++; $display("FAIL timeout_err_count: got %h want 0001", bus.err_count); end
    n = 0;
    while (!bus.tx_enable && n < GAP_CYC + 20) begin @(negedge clk); n++; end
    checks++; if (cyc !== at + GAP_CYC) begin fails++; $display("FAIL timeout_gap_len: got %0d want %0d", cyc - at, GAP_CYC); end
    wait_idle("timeout");
  endtask

  task automatic test_bad_frame();
    logic [NREQ-1:0] g, d;
    logic            ok;
    int              at;
    bus.req = 4'b0100;
    wait_grant("bad", g);
    bus.req = 4'b0000;
    wait_rxwait("bad");
    repeat (5) @(negedge clk);
    pulse_eop(1'b0);
    wait_done("bad", d, ok, at);
    checks++; if (d !== 4'b0100) begin fails++; $display("FAIL bad_done: got %b want 0100", d); end
    checks++; if (ok !== 1'b0) begin fails++; $display("FAIL bad_resp_ok: got %b want 0", ok); end
    checks++; if (bus.err_count !== 16'd2) begin fails++; $display("FAIL bad_err_count: got %h want 0002", bus.err_count); end
    wait_idle("bad");
  endtask

  task automatic test_frame_vs_timeout();
    logic [NREQ-1:0] g, d;
    logic            ok;
    int              at, fall;
    bus.req = 4'b1000;
    wait_grant("race", g);
    bus.req = 4'b0000;
    wait_rxwait("race");
    fall = busy_fall_cyc;
    // The counter reads 0 on edge fall+1+TIMEOUT_CYC; present the frame for that edge.
    while (cyc < fall + TIMEOUT_CYC) @(negedge clk);
    pulse_eop(1'b1);
    wait_done("race", d, ok, at);
    checks++; if (d !== 4'b1000 || at !== fall + 1 + TIMEOUT_CYC) begin
      fails++; $display("FAIL race_done: got %b at +%0d want 1000 at +%0d", d, at - fall - 1, TIMEOUT_CYC);
    end
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL race_resp_ok: got %b want 1", ok); end
    checks++; if (bus.err_count !== 16'd2) begin fails++; $display("FAIL race_err_count: got %h want 0002", bus.err_count); end
    wait_idle("race");
  endtask

  task automatic test_stray_eop();
    logic [NREQ-1:0] g, d;
    logic            ok;
    int              at, base_done;
    base_done = done_pulses;
    pulse_eop(1'b0);
    repeat (2) @(negedge clk);
    pulse_eop(1'b1);
    repeat (3) @(negedge clk);
    checks++; if (done_pulses !== base_done) begin fails++; $display("FAIL stray_idle_done: got %0d pulses want 0", done_pulses - base_done); end
    checks++; if (bus.err_count !== 16'd2) begin fails++; $display("FAIL stray_idle_err: got %h want 0002", bus.err_count); end
    bus.req = 4'b0001;
    wait_grant("stray", g);
    bus.req = 4'b0000;
    pulse_eop(1'b0);
    checks++; if (done_pulses !== base_done || bus.err_count !== 16'd2) begin
      fails++; $display("FAIL stray_send: got %0d pulses err %h want 0 / 0002", done_pulses - base_done, bus.err_count);
    end
    wait_rxwait("stray");
    pulse_eop(1'b1);
    wait_done("stray", d, ok, at);
    checks++; if (d !== 4'b0001 || ok !== 1'b1) begin fails++; $display("FAIL stray_after: got %b/%b want 0001/1", d, ok); end
    wait_idle("stray");
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g;
    int              base_done;
    bus.req = 4'b0010;
    wait_grant("rstmid", g);
    bus.req = 4'b0000;
    wait_rxwait("rstmid");
    repeat (2) @(negedge clk);
    base_done = done_pulses;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin fails++; $display("FAIL rstmid_grant: got %b want 0000", bus.grant); end
    checks++; if (bus.tx_enable !== 1'b1) begin fails++; $display("FAIL rstmid_tx_enable: got %b want 1", bus.tx_enable); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (TIMEOUT_CYC + 5) @(negedge clk);
    checks++; if (done_pulses !== base_done) begin fails++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_pulses - base_done); end
    checks++; if (bus.err_count !== 16'h0000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_after: err=%h busy=%b want 0000/0", bus.err_count, bus.busy);
    end
  endtask

  task automatic test_saturate();
    logic [NREQ-1:0] g, d;
    logic            ok;
    int              at;
    force dut.err_count_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.err_count_q;
    @(negedge clk);
    checks++; if (bus.err_count !== 16'hFFFF) begin fails++; $display("FAIL sat_preload: got %h want ffff", bus.err_count); end
    bus.req = 4'b0001;
    wait_grant("sat", g);
    bus.req = 4'b0000;
    wait_done("sat", d, ok, at);
    checks++; if (d !== 4'b0001 || ok !== 1'b0) begin fails++; $display("FAIL sat_done: got %b/%b want 0001/0", d, ok); end
    checks++; if (bus.err_count !== 16'hFFFF) begin fails++; $display("FAIL sat_err_count: got %h want ffff", bus.err_count); end
    wait_idle("sat");
  endtask

  initial begin
    bus.req            = '0;
    bus.cmd            = '0;
    bus.rx_endofpacket = 1'b0;
    bus.rx_frame_ok    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_bad_frame();
    test_frame_vs_timeout();
    test_stray_eop();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
